// File: rtl/vram_writer.sv
// rtl/vram_writer.sv - cell frame buffer with clear sweep and registered row readout
//
// Stores ROWS words of COLS cell bits. Game logic writes single cells; the VGA
// side reads a whole row per cycle. After reset, and on every clr_req, a
// ROWS-cycle sweep zeroes the frame one row per cycle while writes are stalled.
//
// Ports:
//   clk_25MHz  in   sole clock, rising edge
//   rst_n      in   synchronous reset, active-HIGH despite the name
//   y_pos      in   [5:0] row requested by the VGA controller
//   VRAM       out  [COLS-1:0] registered row contents (bit k = column k)
//   wr_valid   in   cell write request
//   wr_ready   out  cell write can be accepted this cycle (IDLE)
//   wr_x       in   [5:0] write column
//   wr_y       in   [4:0] write row
//   wr_data    in   new cell value
//   clr_req    in   clear whole frame (honoured in IDLE only)
//   busy       out  clear sweep in progress
//   wr_err     out  sticky: an out-of-range write was dropped

module vram_writer #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic            clk_25MHz,
  input  logic            rst_n,
  input  logic [5:0]      y_pos,
  output logic [COLS-1:0] VRAM,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [5:0]      wr_x,
  input  logic [4:0]      wr_y,
  input  logic            wr_data,
  input  logic            clr_req,
  output logic            busy,
  output logic            wr_err
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam logic [5:0] ROWS_W   = 6'(ROWS);
  localparam logic [5:0] COLS_W   = 6'(COLS);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_e          state_q;
  logic [4:0]      clr_cnt_q;
  logic [COLS-1:0] mem_q [ROWS];
  logic [COLS-1:0] vram_q;
  logic [COLS-1:0] vram_d;
  logic            wr_err_q;
  logic            rd_hit;
  logic            wr_hit;

  assign rd_hit = (y_pos < ROWS_W);
  assign wr_hit = (wr_x < COLS_W) && ({1'b0, wr_y} < ROWS_W);

  // Rows beyond the frame read as black rather than aliasing onto real rows.
  always_comb begin
    vram_d = '0;
    if (rd_hit) begin
      vram_d = mem_q[y_pos[4:0]];
    end
  end

  // Memory itself is not reset: the sweep that follows reset zeroes it.
  always_ff @(posedge clk_25MHz) begin
    if (rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      vram_q    <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      // Non-blocking read: a same-cycle write to this row shows up next cycle.
      vram_q <= vram_d;
      case (state_q)
        CLEAR: begin
          mem_q[clr_cnt_q] <= '0;
          if (clr_cnt_q == LAST_ROW) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 5'd1;
          end
        end
        IDLE: begin
          if (wr_valid) begin
            if (wr_hit) begin
              mem_q[wr_y][wr_x] <= wr_data;
            end else begin
              wr_err_q <= 1'b1;
            end
          end
          // Placed after the write so entering CLEAR wins the wr_err update;
          // a coincident in-range write still lands and is swept away.
          if (clr_req) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            wr_err_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= CLEAR;
        end
      endcase
    end
  end

  assign VRAM     = vram_q;
  assign busy     = (state_q == CLEAR);
  assign wr_ready = (state_q == IDLE);
  assign wr_err   = wr_err_q;

endmodule

// File: doc/vram_writer.md
VRAM_WRITER -- requirements
Module: vram_writer

Interface
REQ-001 Parameter COLS, default 40, cells per row; sets the VRAM width.
REQ-002 Parameter ROWS, default 30, rows per frame.
REQ-003 clk_25MHz  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-high (1 = reset) despite its name.
REQ-005 y_pos  input  6  row index requested by the VGA controller.
REQ-006 VRAM  output  COLS  cell bits of the requested row, registered; bit k is column k.
REQ-007 wr_valid  input  1  game logic presents a cell write.
REQ-008 wr_ready  output  1  block can accept a cell write this cycle.
REQ-009 wr_x  input  6  column of the write.
REQ-010 wr_y  input  5  row of the write.
REQ-011 wr_data  input  1  new cell value (1 = occupied/white, 0 = empty/black).
REQ-012 clr_req  input  1  request to clear the whole frame; sampled each cycle.
REQ-013 busy  output  1  high while a clear sweep runs.
REQ-014 wr_err  output  1  sticky flag: an out-of-range write was dropped.

Function
REQ-015 Storage SHALL be ROWS words of COLS bits each.
REQ-016 FSM states SHALL be CLEAR and IDLE only.
REQ-017 In CLEAR, each cycle SHALL zero row clr_cnt and increment clr_cnt.
REQ-018 CLEAR SHALL move to IDLE on the cycle it zeroes row ROWS-1, i.e. after exactly ROWS cycles.
REQ-019 busy SHALL equal (state == CLEAR).
REQ-020 wr_ready SHALL equal (state == IDLE).
REQ-021 A write SHALL be accepted when wr_valid && wr_ready, and takes effect at that clock edge.
REQ-022 An accepted write with wr_x < COLS and wr_y < ROWS SHALL set mem[wr_y][wr_x] = wr_data and leave all other bits unchanged.
REQ-023 An accepted write with wr_x >= COLS or wr_y >= ROWS SHALL leave memory unchanged and set wr_err to 1 on the next edge.
REQ-024 wr_err SHALL clear only on reset or on entry to CLEAR.
REQ-025 wr_valid while wr_ready = 0 SHALL be ignored; the producer holds its request until accepted.
REQ-026 clr_req in IDLE SHALL enter CLEAR on the next edge with clr_cnt = 0.
REQ-027 clr_req while in CLEAR SHALL be ignored; the sweep is neither restarted nor extended.
REQ-028 If clr_req and an accepted write occur in the same IDLE cycle, the write SHALL be performed and the clear SHALL then sweep it away; the final frame is all zeros.
REQ-029 Every cycle, VRAM SHALL load mem[y_pos] (1-cycle latency); y_pos >= ROWS SHALL load all zeros.
REQ-030 Read and write of the same row in the same cycle SHALL return the pre-write value; the new value appears one cycle later.
REQ-031 Reads during CLEAR SHALL return zero for rows already swept and stored data for rows not yet swept.
REQ-032 clr_cnt SHALL be 5 bits; the index arithmetic SHALL never exceed ROWS-1.

Reset
REQ-033 While rst_n = 1, each edge SHALL set: state = CLEAR, clr_cnt = 0, VRAM = 0, wr_err = 0.
REQ-034 The memory SHALL be cleared by the post-reset sweep, not by a single-cycle reset.
REQ-035 After rst_n falls, busy SHALL stay 1 for ROWS edges; wr_ready SHALL rise on the edge that clears row ROWS-1.
REQ-036 Reset asserted mid-sweep or mid-write SHALL restart the sweep from row 0; any pending write is not performed.

Verification
REQ-037 Reset 2 cycles, then release -> busy = 1 for exactly 30 cycles, then wr_ready = 1; VRAM = 0 for every y_pos 0..29.
REQ-038 In IDLE, write (x=5, y=7, d=1), then y_pos = 7 -> VRAM = 40'h0000000020 one cycle after y_pos is applied; y_pos = 6 -> 0.
REQ-039 Write (x=40, y=3) and write (x=0, y=30) -> memory unchanged; wr_err = 1 and stays set; clr_req -> wr_err = 0.
REQ-040 Fill rows 0..29 with all ones; clr_req and a write in the same cycle -> busy for 30 cycles; wr_valid held high stalls until wr_ready; frame all zeros after the sweep.
REQ-041 clr_req re-pulsed at sweep cycle 10 -> sweep still ends at cycle 30.
REQ-041a Reset at sweep cycle 10 -> sweep restarts and ends 30 cycles after reset release.
REQ-042 y_pos = 7 while writing (x=0, y=7, d=1) in the same cycle -> VRAM bit 0 = 0 on the next cycle and 1 on the cycle after.
